// File: rtl/aximm_follower_app.sv
// AXI memory-mapped follower backed by an internal word memory.
// Handles one transaction at a time: a write burst (AW, W beats, B) or a read burst (AR, R beats).
// Ports:
//   clk, rst                 - clock and synchronous active-high reset
//   user_aw*, user_w*, user_b* - write address, data and response channels
//   user_ar*, user_r*          - read address and data channels
//   write_complete           - one-cycle pulse following the B handshake
//   read_complete            - one-cycle pulse following the final R handshake
module aximm_follower_app #(
    parameter int unsigned DWIDTH    = 128,
    parameter int unsigned ADDRWIDTH = 32,
    parameter int unsigned MEM_DEPTH = 256
) (
    input  logic                 clk,
    input  logic                 rst,
    // write address
    input  logic [3:0]           user_awid,
    input  logic [ADDRWIDTH-1:0] user_awaddr,
    input  logic [7:0]           user_awlen,
    input  logic [2:0]           user_awsize,
    input  logic [1:0]           user_awburst,
    input  logic                 user_awvalid,
    output logic                 user_awready,
    // write data
    input  logic [3:0]           user_wid,
    input  logic [DWIDTH-1:0]    user_wdata,
    input  logic [15:0]          user_wstrb,
    input  logic                 user_wlast,
    input  logic                 user_wvalid,
    output logic                 user_wready,
    // write response
    output logic [3:0]           user_bid,
    output logic [1:0]           user_bresp,
    output logic                 user_bvalid,
    input  logic                 user_bready,
    // read address
    input  logic [3:0]           user_arid,
    input  logic [ADDRWIDTH-1:0] user_araddr,
    input  logic [7:0]           user_arlen,
    input  logic [2:0]           user_arsize,
    input  logic [1:0]           user_arburst,
    input  logic                 user_arvalid,
    output logic                 user_arready,
    // read data
    output logic [3:0]           user_rid,
    output logic [DWIDTH-1:0]    user_rdata,
    output logic [1:0]           user_rresp,
    output logic                 user_rlast,
    output logic                 user_rvalid,
    input  logic                 user_rready,
    // completion pulses
    output logic                 write_complete,
    output logic                 read_complete
);

    localparam int unsigned IDX_W  = $clog2(MEM_DEPTH);
    localparam int unsigned NBYTES = DWIDTH / 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR_DATA = 2'd1,
        WR_RESP = 2'd2,
        RD_DATA = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [DWIDTH-1:0] mem [MEM_DEPTH];

    // write burst context
    logic [3:0]       wr_id;
    logic [IDX_W-1:0] wr_idx;
    logic [7:0]       wr_len;
    logic [1:0]       wr_burst;
    logic [8:0]       wr_beats;

    // read burst context
    logic [IDX_W-1:0] rd_idx;
    logic [7:0]       rd_len;
    logic [1:0]       rd_burst;
    logic [7:0]       rd_beat;

    logic aw_hs;
    logic w_hs;
    logic b_hs;
    logic ar_hs;
    logic r_hs;

    logic [IDX_W-1:0]  wr_next_idx;
    logic [IDX_W-1:0]  rd_next_idx;
    logic [IDX_W-1:0]  ar_start_idx;
    logic [8:0]        wr_beats_inc;
    logic              wr_ok;
    logic [DWIDTH-1:0] wr_mask;

    // Ready decodes are gated by rst so nothing handshakes while reset is held.
    assign user_awready = (state == IDLE) && !rst;
    assign user_arready = (state == IDLE) && !rst && !user_awvalid;
    assign user_wready  = (state == WR_DATA) && !rst;
    assign user_rresp   = 2'b00;

    assign aw_hs = user_awvalid && user_awready;
    assign w_hs  = user_wvalid && user_wready;
    assign b_hs  = user_bvalid && user_bready;
    assign ar_hs = user_arvalid && user_arready;
    assign r_hs  = user_rvalid && user_rready;

    // FIXED bursts stay on one word; INCR and WRAP step through the memory modulo its depth.
    assign wr_next_idx  = (wr_burst == 2'b00) ? wr_idx : wr_idx + IDX_W'(1);
    assign rd_next_idx  = (rd_burst == 2'b00) ? rd_idx : rd_idx + IDX_W'(1);
    assign ar_start_idx = user_araddr[IDX_W+3:4];

    // A burst ending one beat early is still reported OKAY.
    assign wr_beats_inc = wr_beats + 9'd1;
    assign wr_ok        = (wr_beats_inc == ({1'b0, wr_len} + 9'd1)) ||
                          (wr_beats_inc == {1'b0, wr_len});

    // Expand byte strobes into a bit mask.
    for (genvar b = 0; b < NBYTES; b++) begin : g_mask
        assign wr_mask[b*8 +: 8] = {8{user_wstrb[b]}};
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; write wins a simultaneous AW/AR via the arready decode.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (aw_hs) begin
                    state_nxt = WR_DATA;
                end else if (ar_hs) begin
                    state_nxt = RD_DATA;
                end
            end
            WR_DATA: begin
                if (w_hs && user_wlast) begin
                    state_nxt = WR_RESP;
                end
            end
            WR_RESP: begin
                if (b_hs) begin
                    state_nxt = IDLE;
                end
            end
            RD_DATA: begin
                if (r_hs && user_rlast) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Memory write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (w_hs) begin
            mem[wr_idx] <= (mem[wr_idx] & ~wr_mask) | (user_wdata & wr_mask);
        end
    end

    // Burst context, B response and registered R beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_id          <= '0;
            wr_idx         <= '0;
            wr_len         <= '0;
            wr_burst       <= '0;
            wr_beats       <= '0;
            user_bvalid    <= 1'b0;
            user_bid       <= '0;
            user_bresp     <= '0;
            rd_idx         <= '0;
            rd_len         <= '0;
            rd_burst       <= '0;
            rd_beat        <= '0;
            user_rvalid    <= 1'b0;
            user_rdata     <= '0;
            user_rlast     <= 1'b0;
            user_rid       <= '0;
            write_complete <= 1'b0;
            read_complete  <= 1'b0;
        end else begin
            write_complete <= b_hs;
            read_complete  <= r_hs && user_rlast;

            if (aw_hs) begin
                wr_id    <= user_awid;
                wr_idx   <= user_awaddr[IDX_W+3:4];
                wr_len   <= user_awlen;
                wr_burst <= user_awburst;
                wr_beats <= '0;
            end

            if (w_hs) begin
                wr_beats <= wr_beats_inc;
                wr_idx   <= wr_next_idx;
                if (user_wlast) begin
                    user_bvalid <= 1'b1;
                    user_bid    <= wr_id;
                    user_bresp  <= wr_ok ? 2'b00 : 2'b10;
                end
            end

            if (b_hs) begin
                user_bvalid <= 1'b0;
            end

            // The next beat is fetched on each accept, so rvalid never drops mid-burst.
            if (ar_hs) begin
                rd_idx      <= ar_start_idx;
                rd_len      <= user_arlen;
                rd_burst    <= user_arburst;
                rd_beat     <= '0;
                user_rvalid <= 1'b1;
                user_rdata  <= mem[ar_start_idx];
                user_rlast  <= (user_arlen == 8'd0);
                user_rid    <= user_arid;
            end else if (r_hs) begin
                if (user_rlast) begin
                    user_rvalid <= 1'b0;
                    user_rlast  <= 1'b0;
                end else begin
                    rd_beat    <= rd_beat + 8'd1;
                    rd_idx     <= rd_next_idx;
                    user_rdata <= mem[rd_next_idx];
                    user_rlast <= ((rd_beat + 8'd1) == rd_len);
                end
            end
        end
    end

    // Sizes and write id carry no meaning here; upper address bits are outside the memory.
    logic unused_ok;
    assign unused_ok = ^{user_awsize, user_arsize, user_wid, user_awaddr, user_araddr, user_wstrb};

endmodule

// File: tb/tb_aximm_follower_app.sv
// Directed bench for aximm_follower_app: write/read bursts, backpressure, AW/AR collision,
// short-burst response codes, FIXED/WRAP addressing, byte strobes and mid-burst reset.
module tb_aximm_follower_app;

    localparam int TMO = 20;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   user_awid;
    logic [31:0]  user_awaddr;
    logic [7:0]   user_awlen;
    logic [2:0]   user_awsize;
    logic [1:0]   user_awburst;
    logic         user_awvalid;
    logic         user_awready;
    logic [3:0]   user_wid;
    logic [127:0] user_wdata;
    logic [15:0]  user_wstrb;
    logic         user_wlast;
    logic         user_wvalid;
    logic         user_wready;
    logic [3:0]   user_bid;
    logic [1:0]   user_bresp;
    logic         user_bvalid;
    logic         user_bready;
    logic [3:0]   user_arid;
    logic [31:0]  user_araddr;
    logic [7:0]   user_arlen;
    logic [2:0]   user_arsize;
    logic [1:0]   user_arburst;
    logic         user_arvalid;
    logic         user_arready;
    logic [3:0]   user_rid;
    logic [127:0] user_rdata;
    logic [1:0]   user_rresp;
    logic         user_rlast;
    logic         user_rvalid;
    logic         user_rready;
    logic         write_complete;
    logic         read_complete;

    int n_vec = 0;
    int n_err = 0;
    int t;

    always #5 clk = ~clk;

    aximm_follower_app dut (
        .clk            (clk),
        .rst            (rst),
        .user_awid      (user_awid),
        .user_awaddr    (user_awaddr),
        .user_awlen     (user_awlen),
        .user_awsize    (user_awsize),
        .user_awburst   (user_awburst),
        .user_awvalid   (user_awvalid),
        .user_awready   (user_awready),
        .user_wid       (user_wid),
        .user_wdata     (user_wdata),
        .user_wstrb     (user_wstrb),
        .user_wlast     (user_wlast),
        .user_wvalid    (user_wvalid),
        .user_wready    (user_wready),
        .user_bid       (user_bid),
        .user_bresp     (user_bresp),
        .user_bvalid    (user_bvalid),
        .user_bready    (user_bready),
        .user_arid      (user_arid),
        .user_araddr    (user_araddr),
        .user_arlen     (user_arlen),
        .user_arsize    (user_arsize),
        .user_arburst   (user_arburst),
        .user_arvalid   (user_arvalid),
        .user_arready   (user_arready),
        .user_rid       (user_rid),
        .user_rdata     (user_rdata),
        .user_rresp     (user_rresp),
        .user_rlast     (user_rlast),
        .user_rvalid    (user_rvalid),
        .user_rready    (user_rready),
        .write_complete (write_complete),
        .read_complete  (read_complete)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", tag, got, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        check({tag, "_awready"}, 128'(user_awready), 128'd0);
        check({tag, "_arready"}, 128'(user_arready), 128'd0);
        check({tag, "_wready"},  128'(user_wready),  128'd0);
        check({tag, "_bvalid"},  128'(user_bvalid),  128'd0);
        check({tag, "_bid"},     128'(user_bid),     128'd0);
        check({tag, "_bresp"},   128'(user_bresp),   128'd0);
        check({tag, "_rvalid"},  128'(user_rvalid),  128'd0);
        check({tag, "_rdata"},   user_rdata,         128'd0);
        check({tag, "_rlast"},   128'(user_rlast),   128'd0);
        check({tag, "_rid"},     128'(user_rid),     128'd0);
        check({tag, "_rresp"},   128'(user_rresp),   128'd0);
        check({tag, "_wcmp"},    128'(write_complete), 128'd0);
        check({tag, "_rcmp"},    128'(read_complete),  128'd0);
    endtask

    // Write burst of nbeats beats with data base+i; called and returning on a falling edge.
    task automatic do_write(input string tag, input logic [3:0] id, input logic [31:0] addr,
                            input logic [7:0] len, input logic [1:0] burst, input int nbeats,
                            input logic [127:0] base, input logic [15:0] strb,
                            input logic [1:0] exp_resp);
        int tt;
        user_awid    = id;
        user_awaddr  = addr;
        user_awlen   = len;
        user_awburst = burst;
        user_awsize  = 3'd4;
        user_awvalid = 1'b1;
        #1;
        tt = 0;
        while (!user_awready && tt < TMO) begin
            @(negedge clk); #1; tt++;
        end
        check({tag, "_aw_wait"}, 128'(tt < TMO), 128'd1);
        @(negedge clk);
        user_awvalid = 1'b0;
        for (int i = 0; i < nbeats; i++) begin
            user_wdata  = base + 128'(i);
            user_wstrb  = strb;
            user_wlast  = (i == nbeats - 1);
            user_wvalid = 1'b1;
            user_wid    = 4'(i);
            #1;
            tt = 0;
            while (!user_wready && tt < TMO) begin
                @(negedge clk); #1; tt++;
            end
            check({tag, "_w_wait"}, 128'(tt < TMO), 128'd1);
            @(negedge clk);
        end
        user_wvalid = 1'b0;
        user_wlast  = 1'b0;
        tt = 0;
        while (!user_bvalid && tt < TMO) begin
            @(negedge clk); tt++;
        end
        check({tag, "_bvalid"}, 128'(user_bvalid), 128'd1);
        check({tag, "_bid"},    128'(user_bid),    128'(id));
        check({tag, "_bresp"},  128'(user_bresp),  128'(exp_resp));
        @(negedge clk);
        check({tag, "_bhold_valid"}, 128'(user_bvalid), 128'd1);
        check({tag, "_bhold_bid"},   128'(user_bid),    128'(id));
        check({tag, "_wcmp_early"},  128'(write_complete), 128'd0);
        user_bready = 1'b1;
        @(negedge clk);
        user_bready = 1'b0;
        check({tag, "_bvalid_drop"}, 128'(user_bvalid), 128'd0);
        check({tag, "_wcmp_pulse"},  128'(write_complete), 128'd1);
        @(negedge clk);
        check({tag, "_wcmp_end"},    128'(write_complete), 128'd0);
    endtask

    // Read burst (len <= 3); pre_issued means the AR handshake already happened and beat 0 is up.
    task automatic do_read(input string tag, input bit pre_issued, input logic [3:0] id,
                           input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                           input bit toggle, input logic [127:0] e0, input logic [127:0] e1,
                           input logic [127:0] e2, input logic [127:0] e3);
        logic [127:0] exp_d [4];
        int tt;
        int b;
        int c;
        exp_d[0] = e0;
        exp_d[1] = e1;
        exp_d[2] = e2;
        exp_d[3] = e3;
        user_arid    = id;
        user_araddr  = addr;
        user_arlen   = len;
        user_arburst = burst;
        user_arsize  = 3'd4;
        if (!pre_issued) begin
            user_arvalid = 1'b1;
            #1;
            tt = 0;
            while (!user_arready && tt < TMO) begin
                @(negedge clk); #1; tt++;
            end
            check({tag, "_ar_wait"}, 128'(tt < TMO), 128'd1);
            @(negedge clk);
        end
        user_arvalid = 1'b0;
        b = 0;
        c = 0;
        while (b <= int'(len) && c < 4 * TMO) begin
            user_rready = toggle ? (c % 2 == 0) : 1'b1;
            check({tag, "_rvalid"}, 128'(user_rvalid), 128'd1);
            check({tag, "_rdata"},  user_rdata, exp_d[b]);
            check({tag, "_rlast"},  128'(user_rlast), 128'(b == int'(len)));
            check({tag, "_rid"},    128'(user_rid),   128'(id));
            check({tag, "_rresp"},  128'(user_rresp), 128'd0);
            if (user_rready) b++;
            c++;
            @(negedge clk);
        end
        user_rready = 1'b0;
        check({tag, "_beats"},      128'(b), 128'(int'(len) + 1));
        check({tag, "_rvalid_end"}, 128'(user_rvalid), 128'd0);
        check({tag, "_rcmp_pulse"}, 128'(read_complete), 128'd1);
        @(negedge clk);
        check({tag, "_rcmp_end"},   128'(read_complete), 128'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1);
    end

    initial begin
        rst          = 1'b1;
        user_awid    = '0; user_awaddr = '0; user_awlen = '0; user_awsize = '0;
        user_awburst = '0; user_awvalid = 1'b0;
        user_wid     = '0; user_wdata = '0; user_wstrb = '0; user_wlast = 1'b0;
        user_wvalid  = 1'b0; user_bready = 1'b0;
        user_arid    = '0; user_araddr = '0; user_arlen = '0; user_arsize = '0;
        user_arburst = '0; user_arvalid = 1'b0; user_rready = 1'b0;

        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst = 1'b0;
        @(negedge clk);
        check("idle_awready", 128'(user_awready), 128'd1);
        check("idle_arready", 128'(user_arready), 128'd1);

        // Basic 4-beat INCR write and read back, then with rready toggling 1010.
        do_write("wr_a", 4'h3, 32'h0, 8'd3, 2'b01, 4, 128'hA0, 16'hFFFF, 2'b00);
        do_read("rd_a", 1'b0, 4'h6, 32'h0, 8'd3, 2'b01, 1'b0,
                128'hA0, 128'hA1, 128'hA2, 128'hA3);
        do_read("rd_tog", 1'b0, 4'h7, 32'h0, 8'd3, 2'b01, 1'b1,
                128'hA0, 128'hA1, 128'hA2, 128'hA3);

        // Simultaneous AW and AR: write first, read accepted after B; len 0 both ways.
        user_awid = 4'h9; user_awaddr = 32'h100; user_awlen = 8'd0; user_awburst = 2'b01;
        user_awvalid = 1'b1;
        user_arid = 4'hA; user_araddr = 32'h100; user_arlen = 8'd0; user_arburst = 2'b01;
        user_arvalid = 1'b1;
        #1;
        check("col_awready", 128'(user_awready), 128'd1);
        check("col_arready", 128'(user_arready), 128'd0);
        do_write("wr_col", 4'h9, 32'h100, 8'd0, 2'b01, 1, 128'hC0, 16'hFFFF, 2'b00);
        do_read("rd_col", 1'b1, 4'hA, 32'h100, 8'd0, 2'b01, 1'b0,
                128'hC0, 128'h0, 128'h0, 128'h0);

        // Early wlast: two beats short of awlen+1 is SLVERR, one beat short is OKAY.
        do_write("wr_short", 4'h1, 32'h300, 8'd3, 2'b01, 2, 128'hE0, 16'hFFFF, 2'b10);
        do_write("wr_lenm1", 4'h2, 32'h300, 8'd3, 2'b01, 3, 128'hE0, 16'hFFFF, 2'b00);

        // FIXED burst keeps hitting the same word.
        do_write("wr_fix", 4'h4, 32'h200, 8'd1, 2'b00, 2, 128'hD0, 16'hFFFF, 2'b00);
        do_read("rd_fix", 1'b0, 4'h4, 32'h200, 8'd1, 2'b00, 1'b0,
                128'hD1, 128'hD1, 128'h0, 128'h0);

        // Reset while beat 2 of a read is presented.
        user_arid = 4'h5; user_araddr = 32'h0; user_arlen = 8'd3; user_arburst = 2'b01;
        user_arvalid = 1'b1;
        #1;
        t = 0;
        while (!user_arready && t < TMO) begin
            @(negedge clk); #1; t++;
        end
        check("rst_ar_wait", 128'(t < TMO), 128'd1);
        @(negedge clk);
        user_arvalid = 1'b0;
        user_rready  = 1'b1;
        check("rst_beat0", user_rdata, 128'hA0);
        @(negedge clk);
        @(negedge clk);
        check("rst_beat2", user_rdata, 128'hA2);
        rst = 1'b1;
        user_rready = 1'b0;
        @(negedge clk);
        chk_zero("rst_mid");
        rst = 1'b0;
        @(negedge clk);
        check("rst_exit_awready", 128'(user_awready), 128'd1);
        check("rst_exit_rvalid",  128'(user_rvalid),  128'd0);
        check("rst_exit_rcmp",    128'(read_complete), 128'd0);
        do_read("rd_post_rst", 1'b0, 4'h8, 32'h0, 8'd3, 2'b01, 1'b0,
                128'hA0, 128'hA1, 128'hA2, 128'hA3);

        // Index MEM_DEPTH-1 wraps to 0 on the second beat (read back with WRAP code).
        do_write("wr_wrap", 4'hB, 32'hFF0, 8'd1, 2'b01, 2, 128'hB0, 16'hFFFF, 2'b00);
        do_read("rd_wrap", 1'b0, 4'hB, 32'hFF0, 8'd1, 2'b10, 1'b0,
                128'hB0, 128'hB1, 128'h0, 128'h0);
        do_read("rd_idx0", 1'b0, 4'hD, 32'h0, 8'd0, 2'b01, 1'b0,
                128'hB1, 128'h0, 128'h0, 128'h0);

        // Byte strobes: only bytes 3:0 change.
        do_write("wr_ones", 4'hC, 32'h20, 8'd0, 2'b01, 1, '1, 16'hFFFF, 2'b00);
        do_write("wr_strb", 4'hC, 32'h20, 8'd0, 2'b01, 1,
                 128'hAAAAAAAA_AAAAAAAA_AAAAAAAA_12345678, 16'h000F, 2'b00);
        do_read("rd_strb", 1'b0, 4'hC, 32'h20, 8'd0, 2'b01, 1'b0,
                128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_12345678, 128'h0, 128'h0, 128'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/aximm_follower_app.md
AXIMM_FOLLOWER_APP -- requirements
Module: aximm_follower_app

Interface
REQ-001 Parameter DWIDTH, default 128: data width in bits; one beat is 16 bytes.
REQ-002 Parameter ADDRWIDTH, default 32: AXI address width.
REQ-003 Parameter MEM_DEPTH, default 256: number of DWIDTH-bit words in the internal memory; power of two.
REQ-004 Clocking and reset SHALL be: one clock; reset is synchronous and active-high.
REQ-005 clk  in  1  sole clock; all logic on its rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 AW: user_awid in 4, user_awaddr in ADDRWIDTH, user_awlen in 8, user_awsize in 3, user_awburst in 2, user_awvalid in 1, user_awready out 1.
REQ-008 W: user_wid in 4, user_wdata in DWIDTH, user_wstrb in 16, user_wlast in 1, user_wvalid in 1, user_wready out 1.
REQ-009 B: user_bid out 4, user_bresp out 2, user_bvalid out 1, user_bready in 1.
REQ-010 AR: user_arid in 4, user_araddr in ADDRWIDTH, user_arlen in 8, user_arsize in 3, user_arburst in 2, user_arvalid in 1, user_arready out 1.
REQ-011 R: user_rid out 4, user_rdata out DWIDTH, user_rresp out 2, user_rlast out 1, user_rvalid out 1, user_rready in 1.
REQ-012 write_complete  out  1  one-cycle pulse on the B handshake.
REQ-013 read_complete  out  1  one-cycle pulse on the final R handshake.

Function
REQ-014 FSM states SHALL be IDLE, WR_DATA, WR_RESP, RD_DATA; one transaction in flight at a time.
REQ-015 user_awready SHALL be 1 only in IDLE; user_arready SHALL be 1 only in IDLE with user_awvalid=0, so write wins a simultaneous AW/AR request.
REQ-016 IDLE + AW handshake: capture awid, awaddr, awlen, awburst; clear beat counter; go to WR_DATA next cycle.
REQ-017 user_wready SHALL be 1 only in WR_DATA; each W handshake writes user_wdata to the current word index, per-byte gated by user_wstrb, and increments the beat counter.
REQ-018 Word index = addr[log2(MEM_DEPTH)+3:4]. After each beat, INCR (01) and WRAP (10) advance the index by 1 modulo MEM_DEPTH (wrap from MEM_DEPTH-1 to 0); FIXED (00) keeps the index unchanged.
REQ-019 The write burst SHALL end on the W handshake with user_wlast=1, regardless of awlen; go to WR_RESP next cycle.
REQ-020 In WR_RESP: user_bvalid=1, user_bid=captured awid, user_bresp=00 if beats accepted == awlen+1 or == awlen, else 10 (SLVERR); hold stable until user_bready, then go to IDLE and pulse write_complete.
REQ-021 IDLE + AR handshake: capture arid, araddr, arlen, arburst; go to RD_DATA.
REQ-022 user_rvalid SHALL rise the cycle after the AR handshake, with user_rdata equal to memory at the start index; there are no bubbles between beats while user_rready=1.
REQ-023 user_rdata, user_rlast and user_rid SHALL hold stable while user_rvalid=1 and user_rready=0.
REQ-024 Exactly arlen+1 beats SHALL be returned; user_rlast=1 only on beat arlen; user_rresp=00 always.
REQ-025 Final R handshake: user_rvalid drops the next cycle unless a new burst starts; FSM returns to IDLE; read_complete pulses.
REQ-026 user_awsize, user_arsize and user_wid SHALL be ignored.
REQ-027 A burst with len 0 SHALL be legal: one write beat or one read beat, with last asserted.

Reset
REQ-028 While rst=1: state IDLE; every output 0, including ready, valid, id, resp, data, last and the pulses; beat counters 0.
REQ-029 Memory contents SHALL NOT be cleared by reset.
REQ-030 Reset asserted mid-burst SHALL abort the transaction with no B or R response; the first cycle after reset deassertion is IDLE.

Verification
REQ-031 Write awaddr=0x0, awlen=3, 4 beats 0xA0..0xA3 with wstrb=FFFF, wlast on beat 3 -> bvalid with bresp=00 and bid=awid; write_complete pulses once.
REQ-032 Read araddr=0x0, arlen=3 with rready=1 -> rvalid one cycle after AR; data 0xA0..0xA3 on 4 consecutive cycles; rlast only on beat 3; read_complete pulses.
REQ-033 Read the same burst with rready toggled 1010 -> each beat held stable until accepted; sequence unchanged.
REQ-034 awvalid and arvalid asserted in the same cycle -> awready=1, arready=0; the read is accepted after B completes.
REQ-035 Write to index MEM_DEPTH-1 with awlen=1 -> second beat lands at index 0; a wstrb=000F write changes only bytes 3:0.
REQ-036 Assert rst during RD_DATA beat 2 -> all outputs 0 next cycle; a subsequent read returns the previously written data.
